riscv_dmem_arbiter: RTL and testbench
=====================================

Name: riscv_dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory (riscv_dmem) at riscv_top level.
- Port 0 is the CPU load/store path (riscv_dmem_interface output); port 1 is the debug/loader master that preloads or inspects dmem.
- Sequences each access: request/grant, write issue, and fixed-latency read return.
- Fixed priority to port 0, with a starvation counter that guarantees port 1 progress.

Parameters:
- XLEN, 32, data and address width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 8, consecutive waiting cycles of port 1 before it is forced ahead of port 0; legal range 1..255.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req[1:0]  in  2  per-port request, held until granted.
- i_wr_en[1:0]  in  2  per-port write (1) / read (0).
- i_addr0, i_addr1  in  XLEN each  byte address.
- i_byte_sel0, i_byte_sel1  in  4 each  write byte lanes.
- i_wr_data0, i_wr_data1  in  XLEN each  write data.
- o_gnt[1:0]  out  2  one-cycle grant pulse; at most one bit set.
- o_rd_valid[1:0]  out  2  one-cycle read-return pulse to the owning port.
- o_rd_data  out  XLEN  read data, valid with o_rd_valid.
- o_mem_addr  out  XLEN  memory address.
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_byte_sel  out  4  memory byte lanes.
- o_mem_wr_data  out  XLEN  memory write data.
- i_mem_rd_data  in  XLEN  memory read data, RD_LAT cycles after the address.

Behaviour:
- Reset: state ARB_IDLE; o_gnt=0, o_rd_valid=0, o_rd_data=0, o_mem_wr_en=0, o_mem_addr=0, o_mem_byte_sel=0, o_mem_wr_data=0; lat_cnt=0; starve_cnt=0; owner=0.
- Handshake: a requester holds req and all command fields stable until its o_gnt pulse. Dropping req before grant is legal, and the request is then withdrawn. Fields are sampled only in the grant cycle.
- Grant decision, ARB_IDLE only, combinational within the cycle:
  - port 1 wins if i_req[1] && (!i_req[0] || starve_cnt==STARVE_MAX);
  - otherwise port 0 wins if i_req[0].
- Memory command: o_mem_* are driven combinationally from the winner in the grant cycle. o_mem_wr_en = winner's wr_en in that cycle only, 0 otherwise. o_mem_addr/byte_sel/wr_data hold their last values when no grant is issued.
- Write grant: the write completes in the grant cycle. State stays ARB_IDLE, so back-to-back writes at one per cycle are legal.
- Read grant: record owner, load lat_cnt=RD_LAT, go to ARB_RD_WAIT. In ARB_RD_WAIT no grants are issued, and o_mem_addr is held while lat_cnt decrements each cycle.
- Read return: on the edge where lat_cnt reaches 0, o_rd_data <= i_mem_rd_data and o_rd_valid[owner] pulses for one cycle. State returns to ARB_IDLE on that same edge, so a new grant is possible in the cycle o_rd_valid is high.
- Starvation counter (8-bit):
  - increments each cycle i_req[1] is high without o_gnt[1], saturating at STARVE_MAX;
  - clears on o_gnt[1] or when i_req[1] is low;
  - holds during ARB_RD_WAIT.
- Simultaneous requests with starve_cnt<STARVE_MAX: port 0 is granted and port 1 waits.
- A write with byte_sel=4'b0000 is forwarded unchanged; no special handling.
- Reset mid-read: the outstanding read is discarded and no o_rd_valid is produced.
- Address alignment is not checked; that belongs to riscv_dmem_interface.

Decomposition:
- riscv_configs.v gains:
  - ARB_IDLE/ARB_RD_WAIT state encodings (1 bit);
  - default RD_LAT and STARVE_MAX macros.
- Sub-module riscv_arb_prio: combinational priority/starvation grant selector, taking req[1:0] and a starve_hit flag and returning gnt[1:0]. FSM, counters and muxing stay in the top module.

Test Plan:
1. Reset then port 0 write, addr 0x10, data 0xDEADBEEF, byte_sel 4'hF -> o_gnt=2'b01 that cycle with o_mem_wr_en=1 and o_mem_addr=0x10; a later port 0 read of 0x10 returns o_rd_data=0xDEADBEEF with o_rd_valid=2'b01 exactly RD_LAT+1 edges after the grant edge.
2. Both ports request reads every cycle, STARVE_MAX=3 -> grant order 0,0,0,1,0,0,0,1; no two grants closer than RD_LAT+1 cycles.
3. Port 0 issues 4 back-to-back writes with no port 1 request -> o_gnt[0] high 4 consecutive cycles; o_mem_wr_en high 4 cycles.
4. Port 1 read of 0x20, then port 0 request arrives during ARB_RD_WAIT -> port 0 granted in the o_rd_valid[1] cycle, not earlier.
5. i_rst asserted one cycle after a port 1 read grant with RD_LAT=2 -> all outputs 0 immediately (asynchronous); no o_rd_valid after release.
6. Port 1 drops req before being granted while port 0 is busy -> starve_cnt returns to 0; no o_gnt[1] is ever issued.

Source files
------------

// File: rtl/riscv_dmem_arbiter_pkg.sv
// riscv_dmem_arbiter_pkg: shared state encoding and default timing for the dmem arbiter
package riscv_dmem_arbiter_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_RD_WAIT = 1'b1} arb_state_t;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_STARVE_MAX = 8;
endpackage

// File: rtl/riscv_arb_prio.sv
// riscv_arb_prio: port 0 wins unless port 1 is alone or has starved long enough
module riscv_arb_prio (
    input  logic [1:0] req,
    input  logic       starve_hit,
    output logic [1:0] gnt
);
    assign gnt[1] = req[1] && (!req[0] || starve_hit);
    assign gnt[0] = req[0] && !gnt[1];
endmodule

// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter: two-port arbiter for the single-port data memory
module riscv_dmem_arbiter
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_req,
    input  logic [1:0]      i_wr_en,
    input  logic [XLEN-1:0] i_addr0,
    input  logic [XLEN-1:0] i_addr1,
    input  logic [3:0]      i_byte_sel0,
    input  logic [3:0]      i_byte_sel1,
    input  logic [XLEN-1:0] i_wr_data0,
    input  logic [XLEN-1:0] i_wr_data1,
    output logic [1:0]      o_gnt,
    output logic [1:0]      o_rd_valid,
    output logic [XLEN-1:0] o_rd_data,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_wr_en,
    output logic [3:0]      o_mem_byte_sel,
    output logic [XLEN-1:0] o_mem_wr_data,
    input  logic [XLEN-1:0] i_mem_rd_data
);
    arb_state_t      state, state_nxt;
    logic [2:0]      lat_cnt, lat_nxt;
    logic [7:0]      starve_cnt, starve_nxt;
    logic            owner, win, starve_hit, rd_grant, rd_done;
    logic [1:0]      sel;
    logic [XLEN-1:0] addr_q, wd_q;
    logic [3:0]      bs_q;

    assign starve_hit = starve_cnt == 8'(STARVE_MAX);

    riscv_arb_prio u_prio (
        .req        (i_req),
        .starve_hit (starve_hit),
        .gnt        (sel)
    );

    always_comb begin
        o_gnt          = state == ARB_IDLE ? sel : 2'b00;
        win            = o_gnt[1];
        o_mem_addr     = |o_gnt ? (win ? i_addr1 : i_addr0) : addr_q;
        o_mem_byte_sel = |o_gnt ? (win ? i_byte_sel1 : i_byte_sel0) : bs_q;
        o_mem_wr_data  = |o_gnt ? (win ? i_wr_data1 : i_wr_data0) : wd_q;
        o_mem_wr_en    = |o_gnt && i_wr_en[win];
        rd_grant       = |o_gnt && !i_wr_en[win];
        rd_done        = state == ARB_RD_WAIT && lat_cnt == 3'd1;
        state_nxt      = rd_done ? ARB_IDLE : rd_grant ? ARB_RD_WAIT : state;
        lat_nxt        = rd_grant ? 3'(RD_LAT) : state == ARB_RD_WAIT ? lat_cnt - 3'd1 : lat_cnt;
        // the counter freezes while a read is in flight but a withdrawn request still clears it
        starve_nxt     = (!i_req[1] || o_gnt[1]) ? 8'd0 :
                         (state == ARB_RD_WAIT || starve_hit) ? starve_cnt : starve_cnt + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ARB_IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 8'd0;
            owner      <= 1'b0;
            addr_q     <= '0;
            bs_q       <= 4'd0;
            wd_q       <= '0;
            o_rd_valid <= 2'b00;
            o_rd_data  <= '0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_nxt;
            starve_cnt <= starve_nxt;
            owner      <= rd_grant ? win : owner;
            addr_q     <= o_mem_addr;
            bs_q       <= o_mem_byte_sel;
            wd_q       <= o_mem_wr_data;
            o_rd_valid <= rd_done ? (owner ? 2'b10 : 2'b01) : 2'b00;
            o_rd_data  <= rd_done ? i_mem_rd_data : o_rd_data;
        end
    end
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter: random and directed traffic checked against a cycle-count reference model
module tb_riscv_dmem_arbiter;
    localparam int XLEN = 32;
    localparam int RD_LAT = 2;
    localparam int STARVE_MAX = 3;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [1:0]      i_req = 2'b00;
    logic [1:0]      i_wr_en = 2'b00;
    logic [XLEN-1:0] i_addr0 = '0, i_addr1 = '0, i_wr_data0 = '0, i_wr_data1 = '0;
    logic [3:0]      i_byte_sel0 = 4'd0, i_byte_sel1 = 4'd0;
    logic [1:0]      o_gnt, o_rd_valid;
    logic [XLEN-1:0] o_rd_data, o_mem_addr, o_mem_wr_data, i_mem_rd_data;
    logic            o_mem_wr_en;
    logic [3:0]      o_mem_byte_sel;

    always #5 i_clk = ~i_clk;

    riscv_dmem_arbiter #(.XLEN(XLEN), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wr_en(i_wr_en),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_byte_sel0(i_byte_sel0), .i_byte_sel1(i_byte_sel1),
        .i_wr_data0(i_wr_data0), .i_wr_data1(i_wr_data1), .o_gnt(o_gnt), .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data), .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_byte_sel(o_mem_byte_sel), .o_mem_wr_data(o_mem_wr_data), .i_mem_rd_data(i_mem_rd_data)
    );

    // memory with a RD_LAT-deep read pipeline, 16 words addressed by bits [5:2]
    logic [31:0] tb_mem [16] = '{default: 32'd0};
    logic [31:0] pipe [RD_LAT] = '{default: 32'd0};
    assign i_mem_rd_data = pipe[RD_LAT-1];
    always @(posedge i_clk) begin
        pipe[0] <= tb_mem[o_mem_addr[5:2]];
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
        if (o_mem_wr_en)
            for (int b = 0; b < 4; b++)
                if (o_mem_byte_sel[b]) tb_mem[o_mem_addr[5:2]][8*b +: 8] <= o_mem_wr_data[8*b +: 8];
    end

    int checks = 0, failures = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {int at; logic port; logic [31:0] data;} rd_t;
    rd_t         rq[$];
    logic [31:0] mmem [16];
    int          cyc = 0, busy = 0, wait1 = 0;
    logic [31:0] last_addr = 0, last_wd = 0, d_rd;
    logic [3:0]  last_bs = 0;
    logic [1:0]  m_gnt, d_gnt, d_rv;
    logic        d_wr;

    task automatic model_reset();
        rq.delete();
        busy = 0; wait1 = 0; last_addr = 0; last_wd = 0; last_bs = 0;
    endtask

    task automatic drive(int p, logic r, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        i_req[p] = r;
        i_wr_en[p] = w;
        if (p == 0) begin i_addr0 = a; i_byte_sel0 = b; i_wr_data0 = d; end
        else begin i_addr1 = a; i_byte_sel1 = b; i_wr_data1 = d; end
    endtask

    // called at posedge+1 with inputs set; checks mid-cycle, advances the model, returns at next posedge+1
    task automatic step();
        logic [1:0] eg, erv;
        logic       w, ewr;
        #4;
        eg = 2'b00;
        if (busy == 0)
            eg = (i_req[1] && (!i_req[0] || wait1 >= STARVE_MAX)) ? 2'b10 : i_req[0] ? 2'b01 : 2'b00;
        w = eg[1];
        if (eg != 0) begin
            last_addr = w ? i_addr1 : i_addr0;
            last_bs   = w ? i_byte_sel1 : i_byte_sel0;
            last_wd   = w ? i_wr_data1 : i_wr_data0;
        end
        ewr = eg != 0 && i_wr_en[w];
        erv = 2'b00;
        if (rq.size() > 0 && rq[0].at == cyc) begin
            erv = rq[0].port ? 2'b10 : 2'b01;
            check("rd_data", o_rd_data, rq[0].data);
            void'(rq.pop_front());
        end
        check("gnt", 32'(o_gnt), 32'(eg));
        check("rd_valid", 32'(o_rd_valid), 32'(erv));
        check("mem_wr_en", 32'(o_mem_wr_en), 32'(ewr));
        check("mem_addr", o_mem_addr, last_addr);
        check("mem_byte_sel", 32'(o_mem_byte_sel), 32'(last_bs));
        check("mem_wr_data", o_mem_wr_data, last_wd);
        d_gnt = o_gnt; d_rv = o_rd_valid; d_wr = o_mem_wr_en; d_rd = o_rd_data; m_gnt = eg;
        if (ewr) begin
            for (int b = 0; b < 4; b++)
                if (last_bs[b]) mmem[last_addr[5:2]][8*b +: 8] = last_wd[8*b +: 8];
        end else if (eg != 0)
            rq.push_back(rd_t'{at: cyc + RD_LAT + 1, port: w, data: mmem[last_addr[5:2]]});
        wait1 = (!i_req[1] || eg[1]) ? 0 : busy > 0 ? wait1 : wait1 + 1;
        if (busy > 0) busy--;
        if (eg != 0 && !ewr) busy = RD_LAT;
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        i_req = 2'b00;
        repeat (RD_LAT + 2) step();
    endtask

    initial begin
        int gc, last, n0, g1, wcount;
        logic [7:0] order;
        for (int i = 0; i < 16; i++) mmem[i] = 32'd0;
        #12;
        check("rst_gnt", 32'(o_gnt), 0);
        check("rst_rd_valid", 32'(o_rd_valid), 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_mem_wr_en", 32'(o_mem_wr_en), 0);
        check("rst_mem_addr", o_mem_addr, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // write then read back through port 0
        drive(0, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        step();
        check("t1_wr_gnt", 32'(d_gnt), 32'h1);
        check("t1_wr_en", 32'(d_wr), 1);
        drive(0, 1, 0, 32'h10, 4'h0, 32'h0);
        step();
        i_req = 2'b00;
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            step();
            check("t1_rv_timing", 32'(d_rv), k == RD_LAT + 1 ? 32'h1 : 32'h0);
        end
        check("t1_rd_data", d_rd, 32'hDEADBEEF);

        // back-to-back writes
        wcount = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 32'h40 + 32'(4*k), 4'hF, $urandom);
            step();
            if (d_gnt == 2'b01 && d_wr) wcount++;
        end
        check("t3_wr_burst", wcount, 4);
        drain();

        // both ports reading continuously: starvation forces every fourth grant to port 1
        drive(0, 1, 0, 32'h10, 4'h0, 0);
        drive(1, 1, 0, 32'h20, 4'h0, 0);
        gc = 0; last = 0; order = 8'h00;
        for (int n = 0; n < 60 && gc < 8; n++) begin
            step();
            if (d_gnt != 0) begin
                order[gc] = d_gnt[1];
                if (gc > 0) check("t2_gap", cyc - 1 - last, RD_LAT + 1);
                last = cyc - 1;
                gc++;
            end
        end
        check("t2_count", gc, 8);
        check("t2_order", 32'(order), 32'h88);
        drain();

        // port 0 arrives while port 1 read is in flight
        drive(1, 1, 0, 32'h20, 4'h0, 0);
        step();
        check("t4_gnt1", 32'(d_gnt), 32'h2);
        i_req[1] = 1'b0;
        drive(0, 1, 0, 32'h10, 4'h0, 0);
        for (int n = 0; n < 10; n++) begin
            step();
            if (d_gnt != 0) break;
        end
        check("t4_gnt0", 32'(d_gnt), 32'h1);
        check("t4_same_cycle_rv", 32'(d_rv), 32'h2);
        drain();

        // port 1 withdraws while port 0 keeps the memory busy
        drive(0, 1, 0, 32'h10, 4'h0, 0);
        drive(1, 1, 1, 32'h30, 4'hF, 32'h12345678);
        g1 = 0;
        step(); g1 += int'(d_gnt[1]);
        step(); g1 += int'(d_gnt[1]);
        i_req[1] = 1'b0;
        repeat (4) begin step(); g1 += int'(d_gnt[1]); end
        check("t6_no_gnt1", g1, 0);
        i_req[1] = 1'b1;
        n0 = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (d_gnt[1]) break;
            if (d_gnt[0]) n0++;
        end
        check("t6_gnt1_seen", 32'(d_gnt), 32'h2);
        check("t6_port0_before", n0, STARVE_MAX);
        drain();

        // asynchronous reset during a port 1 read
        drive(1, 1, 0, 32'h20, 4'h0, 0);
        step();
        i_req = 2'b00;
        #2;
        i_rst = 1'b1;
        #1;
        check("t5_gnt", 32'(o_gnt), 0);
        check("t5_rd_valid", 32'(o_rd_valid), 0);
        check("t5_rd_data", o_rd_data, 0);
        check("t5_mem_wr_en", 32'(o_mem_wr_en), 0);
        check("t5_mem_addr", o_mem_addr, 0);
        check("t5_mem_byte_sel", 32'(o_mem_byte_sel), 0);
        check("t5_mem_wr_data", o_mem_wr_data, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        repeat (RD_LAT + 3) begin
            step();
            check("t5_no_rv", 32'(d_rv), 0);
        end

        // random traffic
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!i_req[p]) begin
                    if ($urandom_range(0, 2) == 0)
                        drive(p, 1, $urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom);
                end else if (p == 1 && $urandom_range(0, 19) == 0)
                    i_req[1] = 1'b0;
            end
            step();
            for (int p = 0; p < 2; p++) if (m_gnt[p]) i_req[p] = 1'b0;
        end
        drain();
        check("rq_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
